mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Responder end of the cache-control interface.
- Services instruction reads (iREN/iaddr) and data reads/writes (dREN/dWEN/daddr/dstore) issued by the caches block.
- Answers with iwait/iload and dwait/dload.
- Arbitrates one shared single-port RAM driven through a ramstate handshake; data side has priority, with starvation protection for the instruction side.

Parameters:
DSTARVE_MAX, 4, consecutive data grants allowed while iREN pending before instruction side is forced
TIMEOUT, 64, max cycles in an access state before forced error completion (only with MEMARB_TIMEOUT_EN)

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  synchronous active-high reset
iREN  input  1  instruction read request
iaddr  input  32  instruction address
iwait  output  1  low for exactly one cycle when instruction read completes
iload  output  32  instruction data, valid when iwait low
dREN  input  1  data read request
dWEN  input  1  data write request
daddr  input  32  data address
dstore  input  32  write data
dwait  output  1  low for exactly one cycle when data access completes
dload  output  32  read data, valid when dwait low
ramREN  output  1  RAM read strobe
ramWEN  output  1  RAM write strobe
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramstate  input  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
mem_err  output  1  sticky error flag

Behaviour:
- FSM states: IDLE, IREAD, DREAD, DWRITE.
- Reset (sync, RST high at edge): state IDLE, iwait=1, dwait=1, ram strobes 0, ramaddr/ramstore 0, starvation counter 0, mem_err 0.
- Reset mid-access abandons the transaction; strobes drop the following cycle.
- IDLE grant, evaluated each cycle:
  - If starve_cnt==DSTARVE_MAX and iREN: IREAD.
  - Else dWEN: DWRITE. dWEN+dREN together counts as write.
  - Else dREN: DREAD.
  - Else iREN: IREAD.
  - Else stay IDLE.
- At grant: latch address (plus dstore for writes) into internal registers.
- ramaddr/ramstore come from the latched registers, never from live inputs.
- Access state outputs: ramREN=1 (IREAD, DREAD) or ramWEN=1 (DWRITE) every cycle in state; never both.
- Completion: ramstate==ACCESS in an access state.
  - Owning side's wait goes low combinationally that cycle.
  - Owning side's load = ramload (writes: dload=0).
  - Next state IDLE.
- ERROR completion: ramstate==ERROR completes the same way, but load=32'hBAD1BAD1 and mem_err is set (sticky until RST).
- FREE/BUSY in an access state: hold state; wait stays high.
- Back-to-back requests: a requester holding its request after completion is re-granted no earlier than the cycle after IDLE. Minimum 2 cycles per access with zero-latency RAM.
- Requester drops its request mid-access: access runs to completion, result discarded, and the wait pulse is still produced.
- Wait outputs are 1 in every cycle other than a completion cycle.
- iload/dload hold their last completed value when not completing.
- Starvation counter (width clog2(DSTARVE_MAX+1)):
  - Increments on each data grant made while iREN=1.
  - Clears on any instruction grant, and on any data grant made while iREN=0.
  - Saturates at DSTARVE_MAX.

Optional Feature:
MEMARB_TIMEOUT_EN
- Defined:
  - Cycle counter clears on entry to each access state and increments each cycle in it.
  - If it reaches TIMEOUT without ACCESS/ERROR: complete as ERROR (wait low one cycle, load 32'hBAD1BAD1, mem_err set, strobes drop next cycle, return to IDLE).
  - Extra output timeout_err (1 bit, sticky, reset 0) set in the same case.
- Undefined: no counter; access state waits indefinitely; timeout_err port absent.

Test Plan:
- Instruction read: iREN=1, iaddr=0x40, RAM gives ACCESS after 2 BUSY cycles with ramload=0x8C010004 -> ramREN high 3 cycles, ramaddr=0x40, iwait low in the 3rd cycle only with iload=0x8C010004.
- Priority: iREN and dREN asserted the same cycle, daddr=0x100 -> DREAD first (ramaddr=0x100, dwait pulse), then IREAD; iwait stays 1 until its own ACCESS.
- Starvation: iREN held, dWEN held continuously, DSTARVE_MAX=4, zero-latency RAM -> 4 data writes complete, then 5th grant is IREAD, then data resumes.
- Write: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, dstore changed to 0 one cycle after grant -> ramstore stays 0xDEADBEEF, ramWEN=1, dwait low one cycle, dload=0.
- Error/reset: ramstate=ERROR during DREAD -> dload=0xBAD1BAD1, mem_err=1 and stays 1; RST pulsed mid-IREAD -> next cycle ramREN=0, iwait=1, mem_err=0.
- Timeout (MEMARB_TIMEOUT_EN, TIMEOUT=64): ramstate held BUSY -> dwait low in cycle 64 after grant, timeout_err=1, mem_err=1; without macro, still waiting at cycle 200.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared single-port RAM arbiter for the instruction and data cache ports; data side wins, with starvation guard.
// Optional access watchdog enabled by defining MEMARB_TIMEOUT_EN (adds TIMEOUT parameter and timeout_err port).
module mem_arbiter #(
  parameter int DSTARVE_MAX = 4
`ifdef MEMARB_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
`ifdef MEMARB_TIMEOUT_EN
  output logic        timeout_err,
`endif
  output logic        mem_err
);

  localparam int SW = $clog2(DSTARVE_MAX + 1);
  localparam logic [31:0] ERR_WORD = 32'hBAD1BAD1;

  typedef enum logic [1:0] {IDLE, IREAD, DREAD, DWRITE} state_t;

  state_t        r_state, w_next;
  logic [SW-1:0] r_starve;
  logic [31:0]   r_addr, r_store, r_iload, r_dload;
  logic          r_mem_err;
  logic          w_grant_i, w_grant_d, w_done, w_err, w_tmo;
  logic [31:0]   w_load;

`ifdef MEMARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_timeout_err;

  // Counter sits at zero in IDLE, so it is cleared on every entry to an access state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tcnt <= (r_state == IDLE) ? '0 : r_tcnt + TW'(1);
      if (w_tmo) r_timeout_err <= 1'b1;
    end
  end

  assign w_tmo = (r_state != IDLE) && (r_tcnt == TW'(TIMEOUT - 1)) &&
                 (ramstate != 2'd2) && (ramstate != 2'd3);
  assign timeout_err = r_timeout_err;
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_starve == SW'(DSTARVE_MAX) && iREN) begin
          w_next    = IREAD;
          w_grant_i = 1'b1;
        end else if (dWEN) begin
          w_next    = DWRITE;
          w_grant_d = 1'b1;
        end else if (dREN) begin
          w_next    = DREAD;
          w_grant_d = 1'b1;
        end else if (iREN) begin
          w_next    = IREAD;
          w_grant_i = 1'b1;
        end
      end
      default: begin
        if (ramstate == 2'd2 || ramstate == 2'd3 || w_tmo) begin
          w_done = 1'b1;
          w_err  = (ramstate != 2'd2);
          w_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_starve  <= '0;
      r_addr    <= '0;
      r_store   <= '0;
      r_iload   <= '0;
      r_dload   <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant_i) begin
        r_addr   <= iaddr;
        r_starve <= '0;
      end
      if (w_grant_d) begin
        r_addr <= daddr;
        if (dWEN) r_store <= dstore;
        if (!iREN) r_starve <= '0;
        else if (r_starve != SW'(DSTARVE_MAX)) r_starve <= r_starve + SW'(1);
      end
      if (w_done) begin
        if (r_state == IREAD) r_iload <= iload;
        else r_dload <= dload;
        if (w_err) r_mem_err <= 1'b1;
      end
    end
  end

  assign w_load = w_err ? ERR_WORD : ramload;

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = r_iload;
    dload    = r_dload;
    ramREN   = (r_state == IREAD) || (r_state == DREAD);
    ramWEN   = (r_state == DWRITE);
    ramaddr  = r_addr;
    ramstore = r_store;
    mem_err  = r_mem_err;
    if (w_done) begin
      case (r_state)
        IREAD: begin
          iwait = 1'b0;
          iload = w_load;
        end
        DREAD: begin
          dwait = 1'b0;
          dload = w_load;
        end
        default: begin
          dwait = 1'b0;
          dload = w_err ? ERR_WORD : 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-rule model checked every cycle plus hand-computed literal checks.
module tb_mem_arbiter;

  localparam int DSTARVE_MAX = 4;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEMARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.DSTARVE_MAX(DSTARVE_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
`ifdef MEMARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the RAM (0 none, 1 instr read, 2 data read, 3 data write) and the remembered values.
  int          m_own = 0, nx_own;
  int          m_starve = 0, nx_starve;
  logic [31:0] m_addr = 0, m_store = 0, m_iload = 0, m_dload = 0;
  logic [31:0] nx_addr, nx_store, nx_iload, nx_dload;
  logic        m_err = 0, nx_err, m_valid = 0, nx_valid;

  always @(negedge CLK) begin
    logic        cmp, err;
    logic [31:0] val, e_iload, e_dload;
    cmp = (m_own != 0) && (ramstate == 2'd2 || ramstate == 2'd3);
    err = (ramstate == 2'd3);
    val = err ? BAD : ramload;
    e_iload = (cmp && m_own == 1) ? val : m_iload;
    e_dload = (cmp && m_own == 2) ? val : (cmp && m_own == 3) ? (err ? BAD : 32'h0) : m_dload;
    if (m_valid) begin
      chk("m_ramREN",   ramREN,   (m_own == 1 || m_own == 2));
      chk("m_ramWEN",   ramWEN,   (m_own == 3));
      chk("m_ramaddr",  ramaddr,  m_addr);
      chk("m_ramstore", ramstore, m_store);
      chk("m_iwait",    iwait,    !(cmp && m_own == 1));
      chk("m_dwait",    dwait,    !(cmp && m_own >= 2));
      chk("m_iload",    iload,    e_iload);
      chk("m_dload",    dload,    e_dload);
      chk("m_mem_err",  mem_err,  m_err);
    end
    nx_own = m_own; nx_starve = m_starve; nx_addr = m_addr; nx_store = m_store;
    nx_iload = m_iload; nx_dload = m_dload; nx_err = m_err; nx_valid = m_valid;
    if (RST) begin
      nx_own = 0; nx_starve = 0; nx_addr = 0; nx_store = 0;
      nx_iload = 0; nx_dload = 0; nx_err = 0; nx_valid = 1;
    end else if (m_own == 0) begin
      if (iREN && (m_starve == DSTARVE_MAX || !(dWEN || dREN))) begin
        nx_own = 1; nx_addr = iaddr; nx_starve = 0;
      end else if (dWEN || dREN) begin
        nx_own = dWEN ? 3 : 2;
        nx_addr = daddr;
        if (dWEN) nx_store = dstore;
        nx_starve = iREN ? ((m_starve + 1 > DSTARVE_MAX) ? DSTARVE_MAX : m_starve + 1) : 0;
      end
    end else if (cmp) begin
      nx_own = 0;
      if (m_own == 1) nx_iload = e_iload;
      else nx_dload = e_dload;
      if (err) nx_err = 1'b1;
    end
  end

  always @(posedge CLK) begin
    m_own <= nx_own; m_starve <= nx_starve; m_addr <= nx_addr; m_store <= nx_store;
    m_iload <= nx_iload; m_dload <= nx_dload; m_err <= nx_err; m_valid <= nx_valid;
  end

  // Apply one cycle of inputs just after the rising edge, return at the following falling edge.
  task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] ds,
                      input logic [1:0] rs, input logic [31:0] rl);
    @(posedge CLK);
    #1;
    RST = rst; iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
    @(negedge CLK);
  endtask

  logic [5:0] seq;
  int         ncomp;

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ramstate = 2'd0; ramload = 0;
    step(1, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_mem_err", mem_err, 0);

    // Instruction read, two BUSY cycles then ACCESS.
    step(0, 1, 32'h40, 0, 0, 0, 0, 2'd0, 0);
    chk("ird_idle_ren", ramREN, 0);
    step(0, 0, 32'h40, 0, 0, 0, 0, 2'd1, 0);
    chk("ird_c1_ren", ramREN, 1);
    chk("ird_c1_addr", ramaddr, 32'h40);
    chk("ird_c1_iwait", iwait, 1);
    step(0, 0, 32'h40, 0, 0, 0, 0, 2'd1, 0);
    chk("ird_c2_ren", ramREN, 1);
    chk("ird_c2_iwait", iwait, 1);
    step(0, 0, 32'h40, 0, 0, 0, 0, 2'd2, 32'h8C010004);
    chk("ird_c3_ren", ramREN, 1);
    chk("ird_c3_iwait", iwait, 0);
    chk("ird_c3_iload", iload, 32'h8C010004);
    step(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    chk("ird_after_ren", ramREN, 0);
    chk("ird_after_iwait", iwait, 1);
    chk("ird_hold_iload", iload, 32'h8C010004);

    // Data read beats a simultaneous instruction read.
    step(0, 1, 32'h44, 1, 0, 32'h100, 0, 2'd0, 0);
    step(0, 1, 32'h44, 0, 0, 32'h100, 0, 2'd2, 32'h1111);
    chk("pri_addr", ramaddr, 32'h100);
    chk("pri_dwait", dwait, 0);
    chk("pri_dload", dload, 32'h1111);
    chk("pri_iwait", iwait, 1);
    step(0, 1, 32'h44, 0, 0, 0, 0, 2'd0, 0);
    chk("pri_idle_iwait", iwait, 1);
    step(0, 0, 32'h44, 0, 0, 0, 0, 2'd2, 32'h2222);
    chk("pri_i_addr", ramaddr, 32'h44);
    chk("pri_i_iwait", iwait, 0);
    chk("pri_i_iload", iload, 32'h2222);
    step(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);

    // Starvation: continuous writes with iREN held, zero-latency RAM.
    seq = '0; ncomp = 0;
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 32'h48, 0, 1, 32'h300, 32'h55, 2'd2, 32'h3333);
      if (!iwait || !dwait) begin
        seq = {seq[4:0], !iwait};
        ncomp++;
      end
    end
    chk("starve_count", ncomp, 6);
    chk("starve_order", {26'h0, seq}, 32'b000010);
    step(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);

    // Write: dstore changes after the grant, RAM sees the latched value.
    step(0, 0, 0, 0, 1, 32'h200, 32'hDEADBEEF, 2'd0, 0);
    step(0, 0, 0, 0, 0, 32'h200, 32'h0, 2'd1, 0);
    chk("wr_wen", ramWEN, 1);
    chk("wr_ren", ramREN, 0);
    chk("wr_store", ramstore, 32'hDEADBEEF);
    chk("wr_addr", ramaddr, 32'h200);
    step(0, 0, 0, 0, 0, 0, 32'h0, 2'd2, 32'h7777);
    chk("wr_dwait", dwait, 0);
    chk("wr_dload", dload, 0);
    chk("wr_store2", ramstore, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    chk("wr_after_dwait", dwait, 1);

    // ERROR during a data read.
    step(0, 0, 0, 1, 0, 32'h300, 0, 2'd0, 0);
    step(0, 0, 0, 0, 0, 32'h300, 0, 2'd3, 32'h1234);
    chk("err_dwait", dwait, 0);
    chk("err_dload", dload, BAD);
    step(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    chk("err_mem_err", mem_err, 1);
    chk("err_dload_hold", dload, BAD);
    step(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    chk("err_sticky", mem_err, 1);

    // Reset in the middle of an instruction read.
    step(0, 1, 32'h60, 0, 0, 0, 0, 2'd0, 0);
    step(0, 0, 32'h60, 0, 0, 0, 0, 2'd1, 0);
    chk("rmid_ren", ramREN, 1);
    step(1, 0, 0, 0, 0, 0, 0, 2'd1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 2'd1, 0);
    chk("rmid_ren_drop", ramREN, 0);
    chk("rmid_iwait", iwait, 1);
    chk("rmid_mem_err", mem_err, 0);
    chk("rmid_addr", ramaddr, 0);

`ifndef MEMARB_TIMEOUT_EN
    // Without the watchdog a BUSY RAM keeps the data side waiting.
    step(0, 0, 0, 1, 0, 32'h500, 0, 2'd0, 0);
    for (int k = 0; k < 200; k++) step(0, 0, 0, 0, 0, 32'h500, 0, 2'd1, 0);
    chk("nto_dwait", dwait, 1);
    chk("nto_ren", ramREN, 1);
    step(0, 0, 0, 0, 0, 0, 0, 2'd2, 32'h9999);
    chk("nto_done", dwait, 0);
    step(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
